// File: rtl/hazard_pipe_tracker.sv
// Pipeline-register bookkeeping for a 5-stage MIPS-style core: ID/EX, EX/MEM and MEM/WB
// fields for forwarding, load-use stall detection and a saturating stall-cycle counter.
module hazard_pipe_tracker (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs_i,
    input  logic [4:0]  id_rt_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_uses_rt_i,
    input  logic        id_regdst_i,
    input  logic        id_regwrite_i,
    input  logic        id_memread_i,
    input  logic        flush_i,
    output logic [4:0]  RS_addr_IDEX_o,
    output logic [4:0]  RT_addr_IDEX_o,
    output logic [4:0]  Mux_RegDst_EXMEM_o,
    output logic [4:0]  Mux_RegDst_MEMWB_o,
    output logic        EXMEM_WB1_o,
    output logic        MEMWB_WB1_o,
    output logic        stall_o,
    output logic [15:0] stall_cnt_o
);

    logic        r_idex_valid;
    logic [4:0]  r_idex_rs;
    logic [4:0]  r_idex_rt;
    logic [4:0]  r_idex_rd;
    logic        r_idex_regdst;
    logic        r_idex_regwrite;
    logic        r_idex_memread;

    logic [4:0]  r_exmem_dest;
    logic        r_exmem_regwrite;
    logic        r_exmem_memread;

    logic [4:0]  r_memwb_dest;
    logic        r_memwb_regwrite;

    logic [15:0] r_stall_cnt;

    logic        w_stall;
    logic        w_bubble;
    logic [4:0]  w_ex_dest;
    logic        w_ex_regwrite;
    logic        w_cnt_inc;
    logic        w_unused_exmem_memread;

    // Load-use: the load in EX cannot forward its data to the ID consumer in time.
    always_comb begin
        w_stall = 1'b0;
        if (id_valid_i && r_idex_valid && r_idex_memread && (r_idex_rt != 5'd0)) begin
            w_stall = (id_rs_i == r_idex_rt) || (id_uses_rt_i && (id_rt_i == r_idex_rt));
        end
    end

    assign w_bubble      = flush_i | w_stall;
    assign w_ex_dest     = r_idex_regdst ? r_idex_rd : r_idex_rt;
    assign w_ex_regwrite = r_idex_valid & r_idex_regwrite & (w_ex_dest != 5'd0);
    // A flushed stall never happened from the core's point of view, so it is not counted.
    assign w_cnt_inc     = w_stall & ~flush_i & (r_stall_cnt != 16'hFFFF);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_idex_valid    <= 1'b0;
            r_idex_rs       <= 5'd0;
            r_idex_rt       <= 5'd0;
            r_idex_rd       <= 5'd0;
            r_idex_regdst   <= 1'b0;
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
        end else if (w_bubble) begin
            r_idex_valid    <= 1'b0;
            r_idex_rs       <= 5'd0;
            r_idex_rt       <= 5'd0;
            r_idex_rd       <= 5'd0;
            r_idex_regdst   <= 1'b0;
            r_idex_regwrite <= 1'b0;
            r_idex_memread  <= 1'b0;
        end else begin
            r_idex_valid    <= id_valid_i;
            r_idex_rs       <= id_rs_i;
            r_idex_rt       <= id_rt_i;
            r_idex_rd       <= id_rd_i;
            r_idex_regdst   <= id_regdst_i;
            r_idex_regwrite <= id_regwrite_i;
            r_idex_memread  <= id_memread_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_exmem_dest     <= 5'd0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_memread  <= 1'b0;
            r_memwb_dest     <= 5'd0;
            r_memwb_regwrite <= 1'b0;
        end else begin
            r_exmem_dest     <= w_ex_dest;
            r_exmem_regwrite <= w_ex_regwrite;
            r_exmem_memread  <= r_idex_valid & r_idex_memread;
            r_memwb_dest     <= r_exmem_dest;
            r_memwb_regwrite <= r_exmem_regwrite;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= 16'd0;
        end else if (w_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    // EX/MEM memread is held for completeness of the stage; no output consumes it.
    assign w_unused_exmem_memread = r_exmem_memread;

    assign RS_addr_IDEX_o     = r_idex_rs;
    assign RT_addr_IDEX_o     = r_idex_rt;
    assign Mux_RegDst_EXMEM_o = r_exmem_dest;
    assign EXMEM_WB1_o        = r_exmem_regwrite;
    assign Mux_RegDst_MEMWB_o = r_memwb_dest;
    assign MEMWB_WB1_o        = r_memwb_regwrite;
    assign stall_o            = w_stall;
    assign stall_cnt_o        = r_stall_cnt;

endmodule
